mulacc_multi: RTL

- Multi-channel, multi-mode successor to the single-channel running multiply-accumulator.
- Holds NCH independent WIDTH-bit accumulators, each with a sticky overflow flag.
- Operations arrive on a valid/ready command port (channel, opcode, operand); results leave on a valid/ready result port.
- Sits between the command sequencer and downstream datapath consumers. Processes one operation at a time through a fixed 3-state FSM.

---
 rtl/mulacc_multi.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mulacc_multi.sv
// Multi-channel multiply/add/load/read accumulator with sticky per-channel overflow.
// One command at a time: IDLE -> CALC -> OUT, results handed off over valid/ready.

module mulacc_multi_lane #(
  parameter int WIDTH = 8,
  parameter int INIT  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             ovf_d_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] acc_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= WIDTH'(INIT);
      ovf_q <= 1'b0;
    end else if (wr_en_i) begin
      acc_q <= wr_data_i;
      ovf_q <= ovf_d_i;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

module mulacc_multi #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int INIT  = 1,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_err,
  output logic [NCH-1:0]   ovf_flags
);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;
  localparam logic [CH_W:0] NCH_V = (CH_W+1)'(NCH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t               state_q;
  logic [CH_W-1:0]      ch_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     x_q;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 out_valid_q, out_ovf_q, out_err_q;
  logic [CH_W-1:0]      out_ch_q;
  logic [WIDTH-1:0]     out_data_q;

  logic [NCH-1:0][WIDTH-1:0] acc;
  logic [NCH-1:0]            ovf;
  logic [NCH-1:0]            wr_en;
  logic [WIDTH-1:0]          acc_sel;
  logic                      ovf_sel, ovf_res, ch_ok, wb;

  assign ch_ok = {1'b0, ch_q} < NCH_V;

  always_comb begin
    acc_sel = '0;
    ovf_sel = 1'b0;
    if (ch_ok) begin
      acc_sel = acc[ch_q];
      ovf_sel = ovf[ch_q];
    end
  end

  always_comb begin
    res_d = '0;
    case (op_q)
      OP_MUL:  res_d = {{WIDTH{1'b0}}, acc_sel} * {{WIDTH{1'b0}}, x_q};
      OP_ADD:  res_d = {{WIDTH{1'b0}}, acc_sel} + {{WIDTH{1'b0}}, x_q};
      OP_LOAD: res_d = {{WIDTH{1'b0}}, x_q};
      default: res_d = {{WIDTH{1'b0}}, acc_sel};
    endcase
  end

  // New sticky flag for the target channel; LOAD is the only way to clear it short of reset.
  always_comb begin
    ovf_res = ovf_sel | (|res_q[2*WIDTH-1:WIDTH]);
    if (op_q == OP_LOAD) ovf_res = 1'b0;
    else if (op_q == OP_READ) ovf_res = ovf_sel;
  end

  // Writeback happens only on the first cycle of OUT, before out_valid rises.
  assign wb = (state_q == S_OUT) && !out_valid_q && ch_ok && (op_q != OP_READ);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign wr_en[i] = wb && (ch_q == CH_W'(i));
    mulacc_multi_lane #(.WIDTH(WIDTH), .INIT(INIT)) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (wr_en[i]),
      .wr_data_i (res_q[WIDTH-1:0]),
      .ovf_d_i   (ovf_res),
      .acc_o     (acc[i]),
      .ovf_o     (ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      op_q        <= OP_MUL;
      x_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          ch_q    <= in_ch;
          op_q    <= in_op;
          x_q     <= in_x;
          state_q <= S_CALC;
        end
        S_CALC: begin
          res_q   <= res_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= ch_q;
            out_data_q  <= ch_ok ? res_q[WIDTH-1:0] : '0;
            out_ovf_q   <= ch_ok & ovf_res;
            out_err_q   <= !ch_ok;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = reset_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;
  assign ovf_flags = ovf;
endmodule
